// File: rtl/tree_space_arbiter_pkg.sv
// Shared types and helpers for the tree-space arbiter: allocation FSM states
// and the round-robin pointer advance.
package tree_space_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } alloc_state_t;

  // Pointer to the engine after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/tree_space_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after i_ptr
// (wrapping) wins.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int            w_pos;
    logic [IW-1:0] w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_cand = IW'(w_pos);
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tree_space_arbiter.sv
// Merges per-engine node allocation and free requests onto the single
// tree_space_manager allocation and free channels.
module tree_space_arbiter
  import tree_space_arbiter_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int NB_ENGINE      = 2
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic                                swrst,
  input  logic [NB_ENGINE-1:0]                eng_req_valid,
  output logic [NB_ENGINE-1:0]                eng_req_ready,
  output logic [NB_ENGINE*RAM_ADDR_WIDTH-1:0] eng_req_addr,
  input  logic [NB_ENGINE-1:0]                eng_free_valid,
  input  logic [NB_ENGINE-1:0]                eng_free_is_root,
  input  logic [NB_ENGINE*RAM_ADDR_WIDTH-1:0] eng_free_addr,
  output logic [NB_ENGINE-1:0]                eng_free_ready,
  output logic                                mgt_req_valid,
  input  logic                                mgt_req_ready,
  input  logic [RAM_ADDR_WIDTH-1:0]           mgt_req_addr,
  output logic                                mgt_free_valid,
  output logic                                mgt_free_is_root,
  output logic [RAM_ADDR_WIDTH-1:0]           mgt_free_addr,
  input  logic                                mgt_free_ready
);

  localparam int IW = (NB_ENGINE > 1) ? $clog2(NB_ENGINE) : 1;
  localparam int W  = RAM_ADDR_WIDTH;

  alloc_state_t        r_state;
  alloc_state_t        w_state_next;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       r_req_ptr;
  logic [W-1:0]        r_req_addr;

  logic [NB_ENGINE-1:0] w_req_grant;
  logic [IW-1:0]        w_req_idx;
  logic                 w_req_any;

  logic                 r_free_full;
  logic                 r_free_is_root;
  logic [W-1:0]         r_free_addr;
  logic [IW-1:0]        r_free_ptr;

  logic [NB_ENGINE-1:0] w_free_grant;
  logic [IW-1:0]        w_free_idx;
  logic                 w_free_any;
  logic                 w_free_load;
  logic [W-1:0]         w_free_sel_addr;
  logic                 w_free_sel_root;

  rr_arbiter #(.N(NB_ENGINE)) u_req_arb (
    .i_req   (eng_req_valid),
    .i_ptr   (r_req_ptr),
    .o_grant (w_req_grant),
    .o_idx   (w_req_idx),
    .o_any   (w_req_any)
  );

  rr_arbiter #(.N(NB_ENGINE)) u_free_arb (
    .i_req   (eng_free_valid),
    .i_ptr   (r_free_ptr),
    .o_grant (w_free_grant),
    .o_idx   (w_free_idx),
    .o_any   (w_free_any)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_req_any)     w_state_next = ST_REQ;
      ST_REQ:  if (mgt_req_ready) w_state_next = ST_REQ == r_state ? ST_RESP : r_state;
      ST_RESP:                    w_state_next = ST_IDLE;
      default:                    w_state_next = ST_IDLE;
    endcase
  end

  // The grant is registered in IDLE so a requester dropping out mid-grant
  // cannot redirect the address already being fetched.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_req_ptr  <= '0;
      r_req_addr <= '0;
    end else if (swrst) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_req_ptr  <= '0;
      r_req_addr <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: if (w_req_any) r_idx <= w_req_idx;
        ST_REQ:  if (mgt_req_ready) r_req_addr <= mgt_req_addr;
        ST_RESP: r_req_ptr <= IW'(rr_next(int'(r_idx), NB_ENGINE));
        default: ;
      endcase
    end
  end

  always_comb begin
    mgt_req_valid = (r_state == ST_REQ);
    eng_req_ready = '0;
    eng_req_addr  = '0;
    for (int i = 0; i < NB_ENGINE; i++) begin
      if (r_state == ST_RESP && r_idx == IW'(i)) begin
        eng_req_ready[i]        = 1'b1;
        eng_req_addr[i*W +: W]  = r_req_addr;
      end
    end
  end

  always_comb begin
    w_free_load     = ~r_free_full | mgt_free_ready;
    eng_free_ready  = w_free_load ? w_free_grant : '0;
    w_free_sel_addr = '0;
    w_free_sel_root = 1'b0;
    for (int i = 0; i < NB_ENGINE; i++) begin
      if (w_free_idx == IW'(i)) begin
        w_free_sel_addr = eng_free_addr[i*W +: W];
        w_free_sel_root = eng_free_is_root[i];
      end
    end
  end

  // Holding register refills in the same cycle the manager drains it, giving
  // one free per cycle while the manager keeps accepting.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_free_full    <= 1'b0;
      r_free_is_root <= 1'b0;
      r_free_addr    <= '0;
      r_free_ptr     <= '0;
    end else if (swrst) begin
      r_free_full    <= 1'b0;
      r_free_is_root <= 1'b0;
      r_free_addr    <= '0;
      r_free_ptr     <= '0;
    end else if (w_free_load) begin
      r_free_full <= w_free_any;
      if (w_free_any) begin
        r_free_is_root <= w_free_sel_root;
        r_free_addr    <= w_free_sel_addr;
        r_free_ptr     <= IW'(rr_next(int'(w_free_idx), NB_ENGINE));
      end
    end
  end

  assign mgt_free_valid   = r_free_full;
  assign mgt_free_is_root = r_free_is_root;
  assign mgt_free_addr    = r_free_addr;

endmodule

// File: tb/tb_tree_space_arbiter.sv
// Directed self-checking bench for tree_space_arbiter with NB_ENGINE=2,
// RAM_ADDR_WIDTH=16.
module tb_tree_space_arbiter;

  localparam int W = 16;
  localparam int N = 2;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic            swrst = 1'b0;
  logic [N-1:0]    eng_req_valid = '0;
  logic [N-1:0]    eng_req_ready;
  logic [N*W-1:0]  eng_req_addr;
  logic [N-1:0]    eng_free_valid = '0;
  logic [N-1:0]    eng_free_is_root = '0;
  logic [N*W-1:0]  eng_free_addr = '0;
  logic [N-1:0]    eng_free_ready;
  logic            mgt_req_valid;
  logic            mgt_req_ready = 1'b0;
  logic [W-1:0]    mgt_req_addr = '0;
  logic            mgt_free_valid;
  logic            mgt_free_is_root;
  logic [W-1:0]    mgt_free_addr;
  logic            mgt_free_ready = 1'b0;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 aclk = ~aclk;

  tree_space_arbiter #(.RAM_ADDR_WIDTH(W), .NB_ENGINE(N)) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .swrst            (swrst),
    .eng_req_valid    (eng_req_valid),
    .eng_req_ready    (eng_req_ready),
    .eng_req_addr     (eng_req_addr),
    .eng_free_valid   (eng_free_valid),
    .eng_free_is_root (eng_free_is_root),
    .eng_free_addr    (eng_free_addr),
    .eng_free_ready   (eng_free_ready),
    .mgt_req_valid    (mgt_req_valid),
    .mgt_req_ready    (mgt_req_ready),
    .mgt_req_addr     (mgt_req_addr),
    .mgt_free_valid   (mgt_free_valid),
    .mgt_free_is_root (mgt_free_is_root),
    .mgt_free_addr    (mgt_free_addr),
    .mgt_free_ready   (mgt_free_ready)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Waits (bounded) for the next allocation pulse and checks winner and address.
  task automatic applyStimulus(input string tag, input int expIdx, input logic [W-1:0] addr);
    logic [N-1:0] expReady;
    bit           seen;
    expReady     = '0;
    expReady[expIdx] = 1'b1;
    mgt_req_addr = addr;
    seen         = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (eng_req_ready != '0) seen = 1'b1;
    end
    checkOutput({tag, "_ready"}, eng_req_ready, expReady);
    checkOutput({tag, "_addr"}, eng_req_addr[expIdx*W +: W], addr);
    checkOutput({tag, "_validHeld"}, eng_req_ready & ~eng_req_valid, '0);
  endtask

  initial begin
    bit sawReady;

    #2;
    checkOutput("rst_eng_req_ready", eng_req_ready, 0);
    checkOutput("rst_mgt_req_valid", mgt_req_valid, 0);
    checkOutput("rst_mgt_free_valid", mgt_free_valid, 0);
    checkOutput("rst_mgt_free_root", mgt_free_is_root, 0);
    checkOutput("rst_eng_req_addr", eng_req_addr, 0);
    checkOutput("rst_mgt_free_addr", mgt_free_addr, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();

    // Single engine 0 allocation, manager ready with 0x0005.
    eng_req_valid = 2'b01;
    mgt_req_ready = 1'b1;
    mgt_req_addr  = 16'h0005;
    tick();
    checkOutput("single_c1_mgt_valid", mgt_req_valid, 1);
    checkOutput("single_c1_no_ready", eng_req_ready, 0);
    tick();
    checkOutput("single_c2_ready", eng_req_ready, 2'b01);
    checkOutput("single_c2_addr", eng_req_addr[W-1:0], 16'h0005);
    checkOutput("single_c2_mgt_valid", mgt_req_valid, 0);
    eng_req_valid = 2'b00;
    tick();
    checkOutput("single_c3_ready_gone", eng_req_ready, 0);

    // Soft reset restores req_ptr to 0, then two engines contend twice.
    swrst = 1'b1;
    tick();
    swrst = 1'b0;
    eng_req_valid = 2'b11;
    applyStimulus("rr0", 0, 16'h0100);
    applyStimulus("rr1", 1, 16'h0101);
    applyStimulus("rr2", 0, 16'h0102);
    applyStimulus("rr3", 1, 16'h0103);
    eng_req_valid = 2'b00;
    tick();

    // Manager exhausted for 10 cycles in REQ.
    mgt_req_ready = 1'b0;
    eng_req_valid = 2'b01;
    tick();
    sawReady = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (eng_req_ready != '0) sawReady = 1'b1;
    end
    checkOutput("stall_mgt_valid_held", mgt_req_valid, 1);
    checkOutput("stall_no_ready", sawReady, 0);
    mgt_req_ready = 1'b1;
    mgt_req_addr  = 16'h0010;
    tick();
    checkOutput("stall_release_ready", eng_req_ready, 2'b01);
    checkOutput("stall_release_addr", eng_req_addr[W-1:0], 16'h0010);
    eng_req_valid = 2'b00;
    tick();

    // Two simultaneous frees with manager ready: back-to-back delivery.
    mgt_free_ready = 1'b1;
    eng_free_addr  = {16'h0007, 16'h0003};
    eng_free_valid = 2'b11;
    #1;
    checkOutput("free_c0_ready", eng_free_ready, 2'b01);
    tick();
    checkOutput("free_c1_valid", mgt_free_valid, 1);
    checkOutput("free_c1_addr", mgt_free_addr, 16'h0003);
    eng_free_valid = 2'b10;
    #1;
    checkOutput("free_c1_ready", eng_free_ready, 2'b10);
    tick();
    checkOutput("free_c2_addr", mgt_free_addr, 16'h0007);
    checkOutput("free_c2_valid", mgt_free_valid, 1);
    eng_free_valid = 2'b00;
    tick();
    checkOutput("free_c3_empty", mgt_free_valid, 0);

    // Same frees with manager stalled: engine 1 waits, register holds 0x0003.
    mgt_free_ready = 1'b0;
    eng_free_valid = 2'b11;
    #1;
    checkOutput("fstall_c0_ready", eng_free_ready, 2'b01);
    tick();
    eng_free_valid = 2'b10;
    #1;
    checkOutput("fstall_c1_blocked", eng_free_ready, 0);
    tick();
    checkOutput("fstall_c2_blocked", eng_free_ready, 0);
    checkOutput("fstall_c2_hold_addr", mgt_free_addr, 16'h0003);
    checkOutput("fstall_c2_valid", mgt_free_valid, 1);
    mgt_free_ready = 1'b1;
    #1;
    checkOutput("fstall_release_ready", eng_free_ready, 2'b10);
    tick();
    checkOutput("fstall_release_addr", mgt_free_addr, 16'h0007);
    eng_free_valid = 2'b00;
    tick();

    // Root free from engine 1 at address 0.
    eng_free_addr    = {16'h0000, 16'hFFFF};
    eng_free_is_root = 2'b10;
    eng_free_valid   = 2'b10;
    #1;
    checkOutput("root_ready", eng_free_ready, 2'b10);
    tick();
    checkOutput("root_valid", mgt_free_valid, 1);
    checkOutput("root_is_root", mgt_free_is_root, 1);
    checkOutput("root_addr", mgt_free_addr, 16'h0000);
    eng_free_valid   = 2'b00;
    eng_free_is_root = 2'b00;
    tick();

    // Soft reset with allocation in REQ and the free register full.
    mgt_req_ready  = 1'b0;
    mgt_free_ready = 1'b0;
    eng_req_valid  = 2'b01;
    eng_free_addr  = {16'h0000, 16'h0009};
    eng_free_valid = 2'b01;
    tick();
    checkOutput("swrst_pre_req_valid", mgt_req_valid, 1);
    checkOutput("swrst_pre_free_valid", mgt_free_valid, 1);
    eng_free_valid = 2'b00;
    swrst          = 1'b1;
    mgt_req_ready  = 1'b1;
    tick();
    checkOutput("swrst_req_valid", mgt_req_valid, 0);
    checkOutput("swrst_free_valid", mgt_free_valid, 0);
    checkOutput("swrst_free_addr", mgt_free_addr, 0);
    checkOutput("swrst_no_ready", eng_req_ready, 0);
    swrst         = 1'b0;
    eng_req_valid = 2'b00;
    sawReady      = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (eng_req_ready != '0) sawReady = 1'b1;
    end
    checkOutput("swrst_abandoned", sawReady, 0);

    // Pointers back at 0: engine 0 wins both arbiters again.
    mgt_free_ready = 1'b1;
    eng_free_addr  = {16'h0022, 16'h0011};
    eng_free_valid = 2'b11;
    #1;
    checkOutput("swrst_free_ptr", eng_free_ready, 2'b01);
    eng_req_valid = 2'b11;
    applyStimulus("swrst_req_ptr", 0, 16'h0040);
    eng_req_valid  = 2'b00;
    eng_free_valid = 2'b00;
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/tree_space_arbiter.md
# tree_space_arbiter

Arbitration stage directly upstream of `tree_space_manager`: merges the node-address allocation requests and node-free requests of `NB_ENGINE` tree engines (insert, delete, …) onto the manager's single `tree_mgt_req_*` and `tree_mgt_free_*` channels. Allocation uses a registered round-robin grant, capturing the manager's address and returning it to the winning engine. Frees are funnelled through a one-entry holding register with its own round-robin pointer. Both paths run independently.

## Interface
- `RAM_ADDR_WIDTH`, 16, node address width; must match `tree_space_manager`.
- `NB_ENGINE`, 2, number of engine ports, 2..8.
- `aclk  in  1  clock`
- `aresetn  in  1  reset, asynchronous, active-low`
- `swrst  in  1  synchronous soft reset, active-high`
- `eng_req_valid  in  NB_ENGINE  per-engine allocation request; held until eng_req_ready`
- `eng_req_ready  out  NB_ENGINE  one-cycle pulse completing an engine's request`
- `eng_req_addr  out  NB_ENGINE*RAM_ADDR_WIDTH  allocated address, slice i valid while eng_req_ready[i]`
- `eng_free_valid  in  NB_ENGINE  per-engine free request`
- `eng_free_is_root  in  NB_ENGINE  freed node is the tree root`
- `eng_free_addr  in  NB_ENGINE*RAM_ADDR_WIDTH  address to free`
- `eng_free_ready  out  NB_ENGINE  free accepted`
- `mgt_req_valid  out  1`, `mgt_req_ready  in  1`, `mgt_req_addr  in  RAM_ADDR_WIDTH`: to manager allocation channel
- `mgt_free_valid  out  1`, `mgt_free_is_root  out  1`, `mgt_free_addr  out  RAM_ADDR_WIDTH`, `mgt_free_ready  in  1`: to manager free channel

## Operation
- Allocation FSM, states IDLE, REQ, RESP.
  - IDLE: if any `eng_req_valid`, latch winner index from round-robin arbiter (search starts at `req_ptr`), go to REQ. Otherwise stay.
  - REQ: `mgt_req_valid`=1. On `mgt_req_valid & mgt_req_ready`, register `mgt_req_addr` into `addr_q`, go to RESP. If `mgt_req_ready`=0 (manager exhausted), stay in REQ indefinitely.
  - RESP: `eng_req_ready[idx]`=1 and `eng_req_addr[idx]`=`addr_q` for exactly one cycle. `req_ptr` <= (idx+1) mod NB_ENGINE. Return to IDLE.
- Non-selected `eng_req_addr` slices drive 0.
- Engine dropping `eng_req_valid` while granted is a protocol violation; the grant still completes and the address is delivered (bench asserts it never happens).
- Free path: holding register {`full`, `is_root_q`, `addr_q`} drives `mgt_free_*` (`mgt_free_valid`=`full`).
  - Register may load when `~full | mgt_free_ready`.
  - On load, round-robin winner among `eng_free_valid` (from `free_ptr`) gets `eng_free_ready`=1, same cycle, combinational. Its addr/is_root are captured. `free_ptr` <= winner+1.
  - At most one `eng_free_ready` bit is high per cycle.
- `is_root` is forwarded unchanged; filtering stays in the manager.
- `swrst`: FSM to IDLE, both pointers to 0, `full` to 0, registers to 0. Takes priority over every other event that cycle; an in-flight grant is abandoned without response.

## Timing
- Reset values: all `eng_req_ready`, `eng_free_ready`, `mgt_req_valid`, `mgt_free_valid`, `mgt_free_is_root` = 0; `eng_req_addr`, `mgt_free_addr` = 0; `req_ptr`=`free_ptr`=0; FSM IDLE.
- Allocation latency with manager ready: request seen at cycle 0 → `mgt_req_valid` cycle 1 → `eng_req_ready` cycle 2. Throughput is one allocation per 3 cycles.
- Free: accepted the same cycle the register can load; `mgt_free_valid` from the next cycle. Sustained throughput is 1 per cycle while `mgt_free_ready`=1.
- Simultaneous allocation and free on any engines proceed in parallel; there is no cross-path ordering guarantee.

## Structure
- Use existing `bster_h.sv` defines; no new package constants needed. Local typedef for FSM state enum.
- One sub-module `rr_arbiter`, parameters `N`:
  - inputs: request vector, pointer
  - outputs: one-hot grant, winner index, any
  - purely combinational, instantiated twice.
- Target size: ~200 lines including `rr_arbiter`.

## Test plan
- Single engine 0 request, manager returns 0x0005 with ready=1 → `eng_req_ready[0]` pulses at cycle 2 with `eng_req_addr[0]`=0x0005; `req_ptr`=1.
- Engines 0 and 1 request together, twice in a row → grants order 0,1,0,1; each receives the distinct manager address of its handshake.
- Manager `mgt_req_ready`=0 for 10 cycles in REQ → `mgt_req_valid` held, no `eng_req_ready`. Release with addr 0x0010 → delivered 1 cycle later.
- Engines 0 and 1 free 0x0003 and 0x0007 together, `mgt_free_ready`=1 → `mgt_free_addr` 0x0003 then 0x0007 on consecutive cycles. With `mgt_free_ready` held 0, the second engine stalls and `full` holds 0x0003.
- Engine 1 free with is_root=1, addr 0x0000 → `mgt_free_is_root`=1 forwarded with 0x0000.
- `swrst` asserted in REQ state and with `full`=1 → next cycle IDLE, `mgt_req_valid`=`mgt_free_valid`=0, no engine ready pulse, pointers 0.
